si_tag_lane_packer: RTL

//  Tag-aware successor to the fixed 128->N width adapter in the data channel (usr_clk domain, after the header detacher).

---
 rtl/si_tag_lane_packer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/si_tag_lane_packer.sv
// si_tag_lane_packer: drops empty/partial 32-bit tag lanes, compacts surviving tags in order
// and repacks them into OUT_LANES-wide beats, preserving packet boundaries and per-packet tuser.
module si_tag_lane_packer #(
    parameter int IN_LANES  = 4,
    parameter int OUT_LANES = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [32*IN_LANES-1:0]  s_axis_tdata,
    input  logic [4*IN_LANES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [31:0]             s_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [32*OUT_LANES-1:0] m_axis_tdata,
    output logic [4*OUT_LANES-1:0]  m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [31:0]             m_axis_tuser,
    input  logic                    stat_clear,
    output logic [CNT_WIDTH-1:0]    stat_tags,
    output logic [CNT_WIDTH-1:0]    stat_packets,
    output logic [CNT_WIDTH-1:0]    stat_partial
);

    localparam int BUF = IN_LANES + OUT_LANES - 1;
    localparam int CW  = $clog2(BUF + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Registered state
    logic [31:0]          r_buf [BUF];
    logic [CW-1:0]        r_count;
    logic                 r_last_pending;
    logic                 r_in_packet;
    logic                 r_ready_en;
    logic [31:0]          r_tuser;
    logic [CNT_WIDTH-1:0] r_tags;
    logic [CNT_WIDTH-1:0] r_packets;
    logic [CNT_WIDTH-1:0] r_partial;

    // Combinational helpers
    logic [31:0]          w_kept [IN_LANES];
    int                   w_kept_cnt;
    int                   w_part_cnt;
    logic [3:0]           w_nib;
    int                   w_count;
    int                   w_pop_n;
    int                   w_remain;
    int                   w_add;
    logic                 w_tvalid;
    logic                 w_tready;
    logic                 w_fire;
    logic                 w_accept;
    logic [31:0]          w_buf_nxt [BUF];
    logic [CNT_WIDTH-1:0] w_part_add;

    // Classify input lanes and compact the kept tags into lane order
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_kept_cnt = 0;
        w_part_cnt = 0;
        w_nib      = '0;
        for (int j = 0; j < IN_LANES; j++) w_kept[j] = '0;
        for (int i = 0; i < IN_LANES; i++) begin
            w_nib = s_axis_tkeep[4*i +: 4];
            if (w_nib == 4'hF) begin
                for (int j = 0; j < IN_LANES; j++) begin
                    if (j == w_kept_cnt) w_kept[j] = s_axis_tdata[32*i +: 32];
                end
                w_kept_cnt = w_kept_cnt + 1;
            end else if (w_nib != 4'h0) begin
                w_part_cnt = w_part_cnt + 1;
            end
        end
    end

    // Handshake decisions; m_axis_tready feeds s_axis_tready combinationally on purpose
    always_comb begin
        w_count  = int'(r_count);
        w_tvalid = (w_count >= OUT_LANES) || r_last_pending;
        w_tready = r_ready_en && !r_last_pending &&
                   ((w_count < OUT_LANES) || ((w_count < 2*OUT_LANES) && m_axis_tready));
        w_fire   = w_tvalid && m_axis_tready;
        w_accept = s_axis_tvalid && w_tready;
        w_pop_n  = w_fire ? ((w_count < OUT_LANES) ? w_count : OUT_LANES) : 0;
        w_remain = w_count - w_pop_n;
        w_add    = w_accept ? w_kept_cnt : 0;
        w_part_add = w_accept ? CNT_WIDTH'(w_part_cnt) : '0;
    end

    // Next buffer image: shift out fired tags, append accepted tags behind the remainder
    always_comb begin
        for (int i = 0; i < BUF; i++) begin
            w_buf_nxt[i] = '0;
            for (int k = 0; k < BUF; k++) begin
                if ((k == i + w_pop_n) && (k < w_count)) w_buf_nxt[i] = r_buf[k];
            end
            for (int j = 0; j < IN_LANES; j++) begin
                if ((j == i - w_remain) && (j < w_add)) w_buf_nxt[i] = w_kept[j];
            end
        end
    end

    // Output beat is decoded straight from registered buffer state
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            if (j < w_count) begin
                m_axis_tdata[32*j +: 32] = r_buf[j];
                m_axis_tkeep[4*j +: 4]   = 4'hF;
            end
        end
        m_axis_tvalid = w_tvalid;
        m_axis_tlast  = r_last_pending && (w_count <= OUT_LANES);
        m_axis_tuser  = r_tuser;
        s_axis_tready = w_tready;
    end

    // Buffer, packet tracking and tuser latch
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: buffer slots are reset too so tdata reads 0 from reset rather than X.
            for (int i = 0; i < BUF; i++) r_buf[i] <= '0;
            r_count        <= '0;
            r_last_pending <= 1'b0;
            r_in_packet    <= 1'b0;
            r_ready_en     <= 1'b0;
            r_tuser        <= '0;
        end else begin
            r_ready_en <= 1'b1;
            for (int i = 0; i < BUF; i++) r_buf[i] <= w_buf_nxt[i];
            r_count <= CW'(w_remain + w_add);
            if (w_fire && m_axis_tlast) r_last_pending <= 1'b0;
            if (w_accept) begin
                if (!r_in_packet) r_tuser <= s_axis_tuser;
                r_in_packet <= !s_axis_tlast;
                if (s_axis_tlast) r_last_pending <= 1'b1;
            end
        end
    end

    // Statistics counters; clear beats a simultaneous increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tags    <= '0;
            r_packets <= '0;
            r_partial <= '0;
        end else if (stat_clear) begin
            r_tags    <= '0;
            r_packets <= '0;
            r_partial <= '0;
        end else begin
            if (w_fire) begin
                r_tags <= r_tags + CNT_WIDTH'(w_pop_n);
                if (m_axis_tlast) r_packets <= r_packets + CNT_WIDTH'(1);
            end
            if (w_part_add > (CNT_MAX - r_partial)) r_partial <= CNT_MAX;
            else                                    r_partial <= r_partial + w_part_add;
        end
    end

    assign stat_tags    = r_tags;
    assign stat_packets = r_packets;
    assign stat_partial = r_partial;

endmodule
